// File: rtl/sodor5_seq_pkg.sv
// Shared encodings, state type and LFSR step function for the Sodor-5 instruction sequencer.
package sodor5_seq_pkg;

  localparam logic [6:0]  OpImm = 7'b0010011;
  localparam logic [6:0]  OpLui = 7'b0110111;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  localparam logic [11:0] ShiftMaskSr = 12'h41F;
  localparam logic [11:0] ShiftMaskSl = 12'h01F;

  localparam logic [2:0] Funct3Sr = 3'd5;
  localparam logic [2:0] Funct3Sl = 3'd1;

  localparam int unsigned LfsrTapA = 31;
  localparam int unsigned LfsrTapB = 21;
  localparam int unsigned LfsrTapC = 1;
  localparam int unsigned LfsrTapD = 0;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StDrain,
    StDone
  } seq_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[LfsrTapA] ^ l[LfsrTapB] ^ l[LfsrTapC] ^ l[LfsrTapD]};
  endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// 32-bit Fibonacci LFSR with seed load; a zero seed is replaced by 1 to avoid lock-up.
module sodor5_lfsr32
  import sodor5_seq_pkg::*;
#(
  parameter logic [31:0] Seed = 32'h0000_03D7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        advance_i,
  output logic [31:0] lfsr_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sodor5_instr_sequencer.sv
// Deterministic instruction stream for the Sodor-5 imem port: register init, random OP-IMM, NOP drain.
module sodor5_instr_sequencer
  import sodor5_seq_pkg::*;
#(
  parameter int unsigned NUM_INSTR    = 64,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter bit          INIT_EN      = 1'b1,
  parameter logic [31:0] SEED         = 32'h0000_03D7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        seed_we_i,
  input  logic [31:0] seed_in_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] issued_count_o
);

  localparam int unsigned RunW   = (NUM_INSTR > 0) ? $clog2(NUM_INSTR + 1) : 1;
  localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [RunW-1:0]   RunLast   = RunW'(NUM_INSTR - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

  // Empty phases are skipped entirely so no slot is ever issued for them.
  localparam seq_state_e PostRun  = (DRAIN_CYCLES > 0) ? StDrain : StDone;
  localparam seq_state_e PostInit = (NUM_INSTR > 0) ? StRun : PostRun;
  localparam seq_state_e FirstSt  = INIT_EN ? StInit : PostInit;

  seq_state_e        state_q, state_d;
  logic [4:0]        reg_q, reg_d;
  logic              sub_q, sub_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [15:0]       issued_q, issued_d;

  logic        idle_like;
  logic        fire;
  logic        seed_load;
  logic        lfsr_adv;
  logic [31:0] lfsr;
  logic [11:0] run_imm;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign fire      = instr_valid_o & instr_ready_i;
  assign seed_load = seed_we_i & idle_like;
  assign lfsr_adv  = fire & ((state_q == StInit) || (state_q == StRun));

  sodor5_lfsr32 #(
    .Seed(SEED)
  ) u_lfsr (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (seed_load),
    .seed_i   (seed_in_i),
    .advance_i(lfsr_adv),
    .lfsr_o   (lfsr)
  );

  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    sub_d       = sub_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    issued_d    = issued_q;

    if (fire && issued_q != 16'hFFFF) begin
      issued_d = issued_q + 16'd1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        // A simultaneous seed write wins; start is picked up next cycle if still held.
        if (start_i && !seed_we_i) begin
          state_d     = FirstSt;
          reg_d       = 5'd1;
          sub_d       = 1'b0;
          run_cnt_d   = '0;
          drain_cnt_d = '0;
          issued_d    = 16'd0;
        end
      end
      StInit: begin
        if (fire) begin
          sub_d = ~sub_q;
          if (sub_q) begin
            if (reg_q == 5'd31) begin
              state_d = PostInit;
            end else begin
              reg_d = reg_q + 5'd1;
            end
          end
        end
      end
      StRun: begin
        if (fire) begin
          if (run_cnt_q == RunLast) begin
            state_d = PostRun;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (fire) begin
          if (drain_cnt_q == DrainLast) begin
            state_d = StDone;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      reg_q       <= 5'd1;
      sub_q       <= 1'b0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      issued_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      sub_q       <= sub_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      issued_q    <= issued_d;
    end
  end

  always_comb begin
    if (lfsr[14:12] == Funct3Sr) begin
      run_imm = lfsr[31:20] & ShiftMaskSr;
    end else if (lfsr[14:12] == Funct3Sl) begin
      run_imm = lfsr[31:20] & ShiftMaskSl;
    end else begin
      run_imm = lfsr[31:20];
    end
  end

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = Nop;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      StInit: begin
        instr_valid_o = 1'b1;
        busy_o        = 1'b1;
        instr_o       = sub_q ? {lfsr[11:0], reg_q, 3'b000, reg_q, OpImm}
                              : {lfsr[31:12], reg_q, OpLui};
      end
      StRun: begin
        instr_valid_o = 1'b1;
        busy_o        = 1'b1;
        instr_o       = {run_imm, lfsr[19:15], lfsr[14:12], lfsr[11:7], OpImm};
      end
      StDrain: begin
        instr_valid_o = 1'b1;
        busy_o        = 1'b1;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign issued_count_o = issued_q;

endmodule

// File: tb/tb_sodor5_instr_sequencer.sv
// Scoreboard bench: stimulus queues expected words, per-DUT monitors compare on every fire.
module tb_sodor5_instr_sequencer;

  localparam logic [31:0] NopW  = 32'h0000_0013;
  localparam logic [31:0] SeedW = 32'h0000_03D7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_start, a_seed_we, a_ready, a_valid, a_busy, a_done;
  logic [31:0] a_seed_in, a_instr;
  logic [15:0] a_count;
  logic        b_start, b_seed_we, b_ready, b_valid, b_busy, b_done;
  logic [31:0] b_seed_in, b_instr;
  logic [15:0] b_count;

  sodor5_instr_sequencer u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .start_i       (a_start),
    .seed_we_i     (a_seed_we),
    .seed_in_i     (a_seed_in),
    .instr_ready_i (a_ready),
    .instr_valid_o (a_valid),
    .instr_o       (a_instr),
    .busy_o        (a_busy),
    .done_o        (a_done),
    .issued_count_o(a_count)
  );

  sodor5_instr_sequencer #(
    .NUM_INSTR   (4),
    .DRAIN_CYCLES(5),
    .INIT_EN     (1'b0)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .start_i       (b_start),
    .seed_we_i     (b_seed_we),
    .seed_in_i     (b_seed_in),
    .instr_ready_i (b_ready),
    .instr_valid_o (b_valid),
    .instr_o       (b_instr),
    .busy_o        (b_busy),
    .done_o        (b_done),
    .issued_count_o(b_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [31:0] m_run(input logic [31:0] l);
    logic [11:0] imm;
    imm = l[31:20];
    if (l[14:12] == 3'd5) imm = imm & 12'h41F;
    if (l[14:12] == 3'd1) imm = imm & 12'h01F;
    return {imm, l[19:15], l[14:12], l[11:7], 7'b0010011};
  endfunction

  // Model of one full program from a given LFSR value; returns the LFSR value left behind.
  task automatic push_prog(input bit to_b, input bit init_en, input int num, input int drain,
                           input logic [31:0] seed, output logic [31:0] seed_out);
    logic [31:0] l;
    logic [31:0] w;
    logic [4:0]  r;
    l = seed;
    if (init_en) begin
      for (int i = 1; i <= 31; i++) begin
        r = 5'(i);
        w = {l[31:12], r, 7'b0110111};
        if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
        l = m_step(l);
        w = {l[11:0], r, 3'b000, r, 7'b0010011};
        if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
        l = m_step(l);
      end
    end
    for (int i = 0; i < num; i++) begin
      w = m_run(l);
      if (to_b) exp_b.push_back(w); else exp_a.push_back(w);
      l = m_step(l);
    end
    for (int i = 0; i < drain; i++) begin
      if (to_b) exp_b.push_back(NopW); else exp_a.push_back(NopW);
    end
    seed_out = l;
  endtask

  always @(negedge clk) begin
    if (!reset && a_valid && a_ready) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_fire: got %h expected no fire", a_instr);
      end else begin
        check32("a_instr", a_instr, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_valid && b_ready) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_fire: got %h expected no fire", b_instr);
      end else begin
        check32("b_instr", b_instr, exp_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(input int budget);
    int k;
    k = 0;
    while (!a_done && k < budget) begin
      tick();
      k++;
    end
    check32("a_done_reached", 32'(a_done), 32'd1);
  endtask

  task automatic wait_a_count(input logic [15:0] target, input int budget);
    int k;
    k = 0;
    while (a_count != target && k < budget) begin
      tick();
      k++;
    end
    check32("a_count_reached", 32'(a_count), 32'(target));
  endtask

  logic [31:0] la;

  initial begin
    reset     = 1'b1;
    a_start   = 1'b0; a_seed_we = 1'b0; a_seed_in = '0; a_ready = 1'b0;
    b_start   = 1'b0; b_seed_we = 1'b0; b_seed_in = '0; b_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check32("rst_valid", 32'(a_valid), 32'd0);
    check32("rst_instr", a_instr, NopW);
    check32("rst_busy", 32'(a_busy), 32'd0);
    check32("rst_done", 32'(a_done), 32'd0);
    check32("rst_count", 32'(a_count), 32'd0);
    check32("rst_b_instr", b_instr, NopW);

    // B: seed write beats start, then RUN-only program with masked shift immediate
    push_prog(1'b1, 1'b0, 4, 5, 32'hFFFF_D000, la);
    b_seed_in = 32'hFFFF_D000;
    b_seed_we = 1'b1;
    b_start   = 1'b1;
    b_ready   = 1'b1;
    tick();
    b_seed_we = 1'b0;
    check32("b_seed_prio_busy", 32'(b_busy), 32'd0);
    tick();
    b_start = 1'b0;
    check32("b_first_run", b_instr, 32'h41FF_D013);
    begin
      int k;
      k = 0;
      while (!b_done && k < 40) begin
        tick();
        k++;
      end
    end
    check32("b_done", 32'(b_done), 32'd1);
    check32("b_valid_done", 32'(b_valid), 32'd0);
    check32("b_count", 32'(b_count), 32'd9);
    check32("b_instr_done", b_instr, NopW);
    check32("b_queue_empty", 32'(exp_b.size()), 32'd0);

    // A: full default program with a 3-cycle stall inside INIT
    push_prog(1'b0, 1'b1, 64, 5, SeedW, la);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check32("a_busy", 32'(a_busy), 32'd1);
    check32("a_fire1", a_instr, 32'h0000_00B7);
    a_ready = 1'b1;
    tick();
    check32("a_fire2", a_instr, 32'h7AE0_8093);
    check32("a_count1", 32'(a_count), 32'd1);
    wait_a_count(16'd5, 20);
    a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("stall_instr", a_instr, exp_a[0]);
      check32("stall_count", 32'(a_count), 32'd5);
      check32("stall_busy", 32'(a_busy), 32'd1);
    end
    a_ready = 1'b1;
    wait_a_done(400);
    check32("a_count_total", 32'(a_count), 32'd131);
    check32("a_valid_done", 32'(a_valid), 32'd0);
    check32("a_queue_empty", 32'(exp_a.size()), 32'd0);

    // Restart from DONE continuing the LFSR, then reset mid-RUN
    push_prog(1'b0, 1'b1, 64, 5, la, la);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_a_count(16'd70, 200);
    reset   = 1'b1;
    a_ready = 1'b0;
    tick();
    check32("mid_rst_valid", 32'(a_valid), 32'd0);
    check32("mid_rst_instr", a_instr, NopW);
    check32("mid_rst_count", 32'(a_count), 32'd0);
    check32("mid_rst_busy", 32'(a_busy), 32'd0);
    reset = 1'b0;
    exp_a.delete();
    tick();

    // LFSR reloaded with SEED: the first two words repeat the power-on program
    push_prog(1'b0, 1'b1, 64, 5, SeedW, la);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check32("reseed_fire1", a_instr, 32'h0000_00B7);
    a_ready = 1'b1;
    tick();
    check32("reseed_fire2", a_instr, 32'h7AE0_8093);
    reset   = 1'b1;
    a_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_a.delete();
    tick();

    // Zero seed maps to 1; start while busy is ignored
    a_seed_in = 32'h0;
    a_seed_we = 1'b1;
    tick();
    a_seed_we = 1'b0;
    push_prog(1'b0, 1'b1, 64, 5, 32'h0000_0001, la);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check32("zseed_fire1", a_instr, 32'h0000_00B7);
    a_ready = 1'b1;
    tick();
    check32("zseed_fire2", a_instr, 32'h0030_8093);
    wait_a_count(16'd10, 20);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check32("busy_start_count", 32'(a_count), 32'd11);
    check32("busy_start_busy", 32'(a_busy), 32'd1);
    wait_a_done(400);
    check32("zseed_count_total", 32'(a_count), 32'd131);
    check32("zseed_queue_empty", 32'(exp_a.size()), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
